// File: rtl/apb_master.sv
// Single-initiator APB requester: turns a valid/ready request into SETUP/ACCESS phases.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be at least 1");
    end

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] timeout_cnt_q, timeout_cnt_d;
`endif

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_err_d     = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = req_write;
                    paddr_d     = req_addr;
                    pwdata_d    = req_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
                    timeout_cnt_d = 32'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A ready slave always wins, even in the cycle the wait limit is reached
                if (PREADY) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!pwrite_q) begin
                        rsp_rdata_d = PRDATA;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                end else if (timeout_cnt_q >= 32'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'hDEAD_BEEF;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 32'd1;
                end
`else
                end else begin
                    state_d = ACCESS;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
            timeout_cnt_q <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q     <= rsp_err_d;
            timeout_cnt_q <= timeout_cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master; outputs sampled 1 time unit after each rising edge.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int vectors = 0;
    int miscompares = 0;

    apb_master #(.TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic sel, input logic en, input logic rdy,
                           input logic vld);
        chk({tag, ".PSEL"}, {31'd0, PSEL}, {31'd0, sel});
        chk({tag, ".PENABLE"}, {31'd0, PENABLE}, {31'd0, en});
        chk({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, rdy});
        chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, vld});
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        tick();
        tick();
        chk_bus("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst.PWRITE", {31'd0, PWRITE}, 32'd0);
        chk("rst.PADDR", PADDR, 32'h0);
        chk("rst.PWDATA", PWDATA, 32'h0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        PRESET = 1'b0;
        tick();
        chk_bus("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Write with zero wait states; PREADY high already in SETUP must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hA5A5_0001;
        PREADY = 1'b1;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        chk_bus("wr.setup", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wr.setup.PADDR", PADDR, 32'h0000_0010);
        chk("wr.setup.PWDATA", PWDATA, 32'hA5A5_0001);
        chk("wr.setup.PWRITE", {31'd0, PWRITE}, 32'd1);
        tick();
        chk_bus("wr.access", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("wr.access.PADDR", PADDR, 32'h0000_0010);
        chk("wr.access.PWDATA", PWDATA, 32'hA5A5_0001);
        tick();
        chk_bus("wr.rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("wr.rsp.err", {31'd0, rsp_err}, 32'd0);
        chk("wr.rsp.rdata", rsp_rdata, 32'h0);
        tick();
        chk_bus("wr.after", 1'b0, 1'b0, 1'b1, 1'b0);

        // Read with two wait states
        PREADY = 1'b0; PRDATA = 32'hBAD0_BAD0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0004;
        tick();
        req_valid = 1'b0;
        chk_bus("rd.setup", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rd.setup.PWRITE", {31'd0, PWRITE}, 32'd0);
        tick();
        chk_bus("rd.wait1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("rd.wait2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("rd.access3", 1'b1, 1'b1, 1'b0, 1'b0);
        PREADY = 1'b1; PRDATA = 32'h1234_5678;
        tick();
        PREADY = 1'b0; PRDATA = 32'h0;
        chk_bus("rd.rsp", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rd.rsp.rdata", rsp_rdata, 32'h1234_5678);
        chk("rd.rsp.err", {31'd0, rsp_err}, 32'd0);
        tick();
        chk_bus("rd.after", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd.after.rdata", rsp_rdata, 32'h1234_5678);

        // Back-to-back writes with req_valid held high
        PREADY = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h1111_2222;
        tick();
        req_addr = 32'h0000_0024; req_wdata = 32'h3333_4444;
        chk_bus("b2b.setup1", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b.setup1.PADDR", PADDR, 32'h0000_0020);
        tick();
        chk_bus("b2b.access1", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("b2b.access1.PADDR", PADDR, 32'h0000_0020);
        tick();
        chk_bus("b2b.rsp1", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        req_valid = 1'b0;
        chk_bus("b2b.setup2", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b.setup2.PADDR", PADDR, 32'h0000_0024);
        chk("b2b.setup2.PWDATA", PWDATA, 32'h3333_4444);
        tick();
        chk_bus("b2b.access2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("b2b.rsp2", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("b2b.rsp2.rdata_kept", rsp_rdata, 32'h1234_5678);
        tick();
        tick();
        chk("idle.PADDR_hold", PADDR, 32'h0000_0024);
        chk("idle.PWRITE_hold", {31'd0, PWRITE}, 32'd1);

        // Asynchronous reset in the middle of ACCESS
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0030;
        tick();
        req_valid = 1'b0;
        tick();
        chk_bus("rstmid.access", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        PRESET = 1'b1;
        #1;
        chk_bus("rstmid.async", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstmid.PADDR", PADDR, 32'h0);
        chk("rstmid.rdata", rsp_rdata, 32'h0);
        PREADY = 1'b1;
        tick();
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bus("rstmid.after", 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Slave that never responds
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0008;
        tick();
        req_valid = 1'b0;
        chk_bus("to.setup", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_bus("to.wait", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_bus("to.abort", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("to.abort.err", {31'd0, rsp_err}, 32'd1);
        chk("to.abort.rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();
        chk_bus("to.after", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("to.after.err", {31'd0, rsp_err}, 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_bus("to.wait", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
        tick();
        PREADY = 1'b0;
        chk_bus("to.done", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("to.done.err", {31'd0, rsp_err}, 32'd0);
        chk("to.done.rdata", rsp_rdata, 32'hCAFE_F00D);
        tick();
        chk_bus("to.after", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
